// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scanner with a guard gap between digits,
// frame-aligned double buffering of the displayed value and leading-zero blanking.
module seg_scan_ctrl #(
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        lz_blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic [1:0]  digit_sel,
  output logic        frame_start,
  output logic        overrun
);

  localparam int CMAX = (PRESCALE > GUARD) ? PRESCALE : GUARD;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_GUARD = 1'b1
  } state_t;

  // Active-low hex font, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] f;
    case (nib)
      4'h0: f = 7'b1000000;
      4'h1: f = 7'b1111001;
      4'h2: f = 7'b0100100;
      4'h3: f = 7'b0110000;
      4'h4: f = 7'b0011001;
      4'h5: f = 7'b0010010;
      4'h6: f = 7'b0000010;
      4'h7: f = 7'b1111000;
      4'h8: f = 7'b0000000;
      4'h9: f = 7'b0010000;
      4'hA: f = 7'b0001000;
      4'hB: f = 7'b0000011;
      4'hC: f = 7'b1000110;
      4'hD: f = 7'b0100001;
      4'hE: f = 7'b0000110;
      4'hF: f = 7'b0001110;
      default: f = 7'b1111111;
    endcase
    return f;
  endfunction

  state_t      state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [1:0]  ptr_r, ptr_s;
  logic [15:0] active_r, active_s;
  logic [15:0] pending_r, pending_s;
  logic        pend_v_r, pend_v_s;
  logic        wrap_s, consume_s, blank_s, show_s;
  logic        overrun_s;
  logic [3:0]  nib_s;
  logic [3:0]  an_s;
  logic [6:0]  seg_s;

  // Next-state logic: dwell sequencing, pointer advance and buffer hand-over.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r + CW'(1);
    ptr_s     = ptr_r;
    active_s  = active_r;
    pending_s = pending_r;
    pend_v_s  = pend_v_r;
    overrun_s = 1'b0;
    wrap_s    = 1'b0;
    case (state_r)
      ST_SHOW: begin
        if (cnt_r == CW'(PRESCALE - 1)) begin
          state_s = ST_GUARD;
          cnt_s   = '0;
        end else begin
          state_s = ST_SHOW;
        end
      end
      ST_GUARD: begin
        if (cnt_r == CW'(GUARD - 1)) begin
          state_s = ST_SHOW;
          cnt_s   = '0;
          ptr_s   = ptr_r + 2'd1;
          wrap_s  = (ptr_r == 2'd3);
        end else begin
          state_s = ST_GUARD;
        end
      end
      default: begin
        state_s = ST_GUARD;
        cnt_s   = '0;
      end
    endcase

    consume_s = wrap_s & pend_v_r;
    if (consume_s) begin
      active_s = pending_r;
      pend_v_s = 1'b0;
    end else begin
      active_s = active_r;
    end

    // A load on the wrap edge lands behind the transfer, so it never overruns.
    if (load) begin
      pending_s = value;
      pend_v_s  = 1'b1;
      overrun_s = pend_v_r & ~consume_s;
    end else begin
      overrun_s = 1'b0;
    end
  end

  // Output decode from the upcoming state so outputs leave flops directly.
  always_comb begin
    show_s = (state_s == ST_SHOW);
    nib_s  = active_s[{ptr_s, 2'b00} +: 4];
    case (ptr_s)
      2'd1:    blank_s = lz_blank & (active_s[15:4] == 12'h000);
      2'd2:    blank_s = lz_blank & (active_s[15:8] == 8'h00);
      2'd3:    blank_s = lz_blank & (active_s[15:12] == 4'h0);
      default: blank_s = 1'b0;
    endcase
    if (show_s && !blank_s) begin
      an_s  = ~(4'b0001 << ptr_s);
      seg_s = hex_font(nib_s);
    end else begin
      an_s  = 4'b1111;
      seg_s = 7'b1111111;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_GUARD;
      cnt_r       <= '0;
      ptr_r       <= 2'd3;
      active_r    <= 16'h0000;
      pending_r   <= 16'h0000;
      pend_v_r    <= 1'b0;
      an          <= 4'b1111;
      seg         <= 7'b1111111;
      digit_sel   <= 2'd3;
      frame_start <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      ptr_r       <= ptr_s;
      active_r    <= active_s;
      pending_r   <= pending_s;
      pend_v_r    <= pend_v_s;
      an          <= an_s;
      seg         <= seg_s;
      digit_sel   <= ptr_s;
      frame_start <= wrap_s;
      overrun     <= overrun_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a timeline model predicts every cycle's
// outputs, and a negedge monitor compares them against the DUT.
module tb_seg_scan_ctrl;

  localparam int P = 4;
  localparam int G = 2;
  localparam int S = P + G;
  localparam int F = 4 * S;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [1:0]  digit_sel;
  logic        frame_start;
  logic        overrun;

  seg_scan_ctrl #(.PRESCALE(P), .GUARD(G)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .lz_blank(lz_blank),
    .an(an), .seg(seg), .digit_sel(digit_sel),
    .frame_start(frame_start), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] ds;
    logic       fs;
    logic       ov;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [6:0] font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model: u counts cycles since reset; frames start G cycles in.
  int          u = 0;
  logic [15:0] m_act = 16'h0000;
  logic [15:0] m_pend = 16'h0000;
  logic        m_pv = 1'b0;
  logic        cur_lz = 1'b0;

  function automatic bit is_wrap(input int t);
    return (t >= G) && (((t - G) % F) == 0);
  endfunction

  task automatic step(input logic r, input logic ld, input logic [15:0] v);
    exp_t e;
    bit   wrap, consume, ov;
    int   d, w, k;
    rst = r; load = ld; value = v; lz_blank = cur_lz;
    ov = 1'b0;
    if (r) begin
      u = 0; m_act = 16'h0000; m_pend = 16'h0000; m_pv = 1'b0;
    end else begin
      u = u + 1;
      wrap = is_wrap(u);
      consume = wrap && m_pv;
      if (consume) begin
        m_act = m_pend;
        m_pv = 1'b0;
      end
      if (ld) begin
        ov = m_pv;
        m_pend = v;
        m_pv = 1'b1;
      end
    end
    e.an = 4'b1111; e.seg = 7'b1111111; e.fs = 1'b0; e.ov = ov;
    if (u < G) begin
      e.ds = 2'd3;
    end else begin
      d = ((u - G) % F) / S;
      w = ((u - G) % F) % S;
      e.ds = 2'(d);
      if (w < P) begin
        e.fs = (d == 0) && (w == 0);
        k = (int'(m_act) >> (4 * d));
        if (!(cur_lz && d > 0 && k == 0)) begin
          e.an  = ~(4'b0001 << d);
          e.seg = font[k & 15];
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000);
  endtask

  // Monitor: compare each post-edge output against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (an !== e.an || seg !== e.seg || digit_sel !== e.ds ||
            frame_start !== e.fs || overrun !== e.ov) begin
          miscompares++;
          $display("FAIL cycle_outputs t=%0t got an=%b seg=%b ds=%0d fs=%b ov=%b exp an=%b seg=%b ds=%0d fs=%b ov=%b",
                   $time, an, seg, digit_sel, frame_start, overrun,
                   e.an, e.seg, e.ds, e.fs, e.ov);
        end
      end
    end
  end

  initial begin
    logic [15:0] v;
    int guard_cnt;
    // Reset and an idle frame of zeros.
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 16'hBEEF);
    step(1'b1, 1'b0, 16'h0000);
    idle(30);
    // Mid-frame load with a mixed-digit value.
    step(1'b0, 1'b1, 16'h12AF);
    idle(50);
    // Leading-zero blanking on and off.
    cur_lz = 1'b1;
    step(1'b0, 1'b1, 16'h0005);
    idle(50);
    cur_lz = 1'b0;
    idle(30);
    // Two loads in one frame.
    step(1'b0, 1'b1, 16'h1111);
    idle(3);
    step(1'b0, 1'b1, 16'h2222);
    idle(50);
    // Load exactly on the wrap edge while a value is pending.
    step(1'b0, 1'b1, 16'h4444);
    guard_cnt = 0;
    while (!is_wrap(u + 1) && guard_cnt < 100) begin
      idle(1);
      guard_cnt++;
    end
    step(1'b0, 1'b1, 16'h3333);
    idle(60);
    // Reset during digit 2 with a pending value.
    step(1'b0, 1'b1, 16'h5555);
    guard_cnt = 0;
    while (!((u >= G) && (((u - G) % F) == 2 * S + 1)) && guard_cnt < 100) begin
      idle(1);
      guard_cnt++;
    end
    step(1'b1, 1'b1, 16'h7777);
    idle(40);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       v = 16'($urandom);
        1:       v = {12'h000, 4'($urandom)};
        2:       v = {8'h00, 8'($urandom)};
        default: v = 16'h0000;
      endcase
      if ($urandom_range(0, 199) == 0) cur_lz = ~cur_lz;
      if ($urandom_range(0, 499) == 0)
        step(1'b1, 1'($urandom), v);
      else if (is_wrap(u + 1) && m_pv && $urandom_range(0, 1) == 1)
        step(1'b0, 1'b1, v);
      else
        step(1'b0, ($urandom_range(0, 15) == 0), v);
    end
    guard_cnt = 0;
    while (exp_q.size() > 0 && guard_cnt < 10) begin
      @(posedge clk);
      guard_cnt++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
